gray_weight_loader: RTL and testbench
=====================================

// Module: gray_weight_loader
// PURPOSE
//  Runtime writer for the gray_filter weight table. Accepts a stream of weight words from the
//  control side (CPU/UART bridge) and writes them into the inactive bank of a 2-bank table RAM.
//  Swaps the bank the filter reads only at the next frame start, so a frame never sees a torn table.
//  Sits between the register/bridge logic and the dual-port table RAM read by gray_filter.
// PARAMETERS
//  DW    12  weight word width (matches filter table data width)
//  AW    9   table address width; DEPTH = 2**AW words per bank
//  SUMW  16  checksum width
// PORTS
//  i_Sys_clk     in   1         system clock; all logic on rising edge
//  i_Rst         in   1         synchronous, active-high reset
//  i_Frame_start in   1         1-cycle pulse at start of each input frame
//  i_Load_start  in   1         1-cycle pulse: begin (or restart) a table load
//  i_Wr_valid    in   1         weight word valid
//  i_Wr_data     in   DW        weight word, sent in address order 0..DEPTH-1
//  o_Wr_ready    out  1         loader accepts word when i_Wr_valid & o_Wr_ready
//  o_Ram_we      out  1         table RAM write enable
//  o_Ram_addr    out  AW+1      {bank, index}; bank = inactive bank
//  o_Ram_wdata   out  DW        table RAM write data
//  o_Rd_bank     out  1         bank the filter must read
//  o_Load_done   out  1         1-cycle pulse when the new table becomes active
//  o_Load_err    out  1         1-cycle pulse when a load in progress is aborted
//  o_Checksum    out  SUMW      modulo-2**SUMW sum of last completed table
// BEHAVIOUR
//  Reset: state=IDLE; o_Wr_ready=0, o_Ram_we=0, o_Ram_addr=0, o_Ram_wdata=0, o_Rd_bank=0,
//   o_Load_done=0, o_Load_err=0, o_Checksum=0; index and running sum cleared.
//  FSM states: IDLE, LOAD, WAIT_SWAP.
//  IDLE: o_Wr_ready=0; i_Load_start -> LOAD with index=0, sum=0. i_Frame_start ignored.
//  LOAD: o_Wr_ready=1. On accept: next cycle o_Ram_we=1, o_Ram_addr={~o_Rd_bank,index},
//   o_Ram_wdata=word (1-cycle registered latency); index+1; sum+=zero-extended word (wraps).
//   Accept at index DEPTH-1 -> WAIT_SWAP next cycle; o_Wr_ready deasserts that same next cycle.
//   i_Frame_start in LOAD: ignored (no swap).
//  WAIT_SWAP: o_Wr_ready=0. On i_Frame_start: o_Rd_bank toggles, o_Load_done=1 and
//   o_Checksum=sum both on the following cycle; -> IDLE.
//  Restart: i_Load_start in LOAD or WAIT_SWAP -> o_Load_err pulse next cycle, index=0, sum=0,
//   stay/enter LOAD; pending swap discarded, o_Rd_bank unchanged. Takes priority over
//   a same-cycle word accept (word dropped) and a same-cycle i_Frame_start (no swap).
//  i_Frame_start in the same cycle as the last word accept: no swap; swap waits for the next frame.
//  Active bank is never written: o_Ram_addr MSB is always ~o_Rd_bank while o_Ram_we=1.
//  i_Rst mid-load: everything returns to reset values; o_Rd_bank returns to 0.
//  Word writes after the final accept are impossible (ready low); no overflow path exists.
// TESTING (bench with AW=3, DEPTH=8)
//  Reset, load words 1..8 back-to-back, frame pulse 5 cycles later -> 8 writes addr 8..15,
//   o_Rd_bank 0->1, o_Load_done 1 cycle, o_Checksum=36.
//  Second load of 0xFFF x8 with random valid gaps -> writes addr 0..7, bank 1->0, checksum=0x7FF8.
//  Load start after 3 words, then full load 10..17 -> o_Load_err 1 cycle, writes restart at index 0,
//   checksum=108 after swap.
//  Frame pulses during LOAD and on last-word cycle -> no swap; next frame pulse swaps, done pulses once.
//  Load start in WAIT_SWAP same cycle as frame pulse -> o_Load_err, o_Rd_bank unchanged, LOAD re-entered.
//  Assert i_Rst after 4 words -> all outputs reset values next cycle, o_Wr_ready=0 until next load start.

Source files
------------

// File: rtl/gray_weight_loader.sv
// Double-buffered weight table writer for gray_filter: streams words into the inactive
// bank and flips the read bank only on a frame boundary once a full table is present.
module gray_weight_loader #(
  parameter int DW   = 12,
  parameter int AW   = 9,
  parameter int SUMW = 16
) (
  input  logic            i_Sys_clk,
  input  logic            i_Rst,
  input  logic            i_Frame_start,
  input  logic            i_Load_start,
  input  logic            i_Wr_valid,
  input  logic [DW-1:0]   i_Wr_data,
  output logic            o_Wr_ready,
  output logic            o_Ram_we,
  output logic [AW:0]     o_Ram_addr,
  output logic [DW-1:0]   o_Ram_wdata,
  output logic            o_Rd_bank,
  output logic            o_Load_done,
  output logic            o_Load_err,
  output logic [SUMW-1:0] o_Checksum
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_SWAP = 2'd2
  } state_t;

  state_t            state_r, next_state_s;
  logic              wr_ready_r;
  logic              ram_we_r;
  logic [AW:0]       ram_addr_r;
  logic [DW-1:0]     ram_wdata_r;
  logic              rd_bank_r;
  logic              load_done_r;
  logic              load_err_r;
  logic [SUMW-1:0]   checksum_r;
  logic [AW-1:0]     index_r;
  logic [SUMW-1:0]   sum_r;

  logic              accept_s;
  logic              last_s;
  logic              restart_s;
  logic              swap_s;

  // Restart outranks both word accept and frame swap in the same cycle.
  assign accept_s = i_Wr_valid && wr_ready_r && !i_Load_start;
  assign last_s   = accept_s && (index_r == {AW{1'b1}});

  // Next-state and per-cycle event decode.
  always_comb begin
    next_state_s = state_r;
    restart_s    = 1'b0;
    swap_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_Load_start) begin
          next_state_s = LOAD;
        end else begin
          next_state_s = IDLE;
        end
      end
      LOAD: begin
        if (i_Load_start) begin
          next_state_s = LOAD;
          restart_s    = 1'b1;
        end else if (last_s) begin
          next_state_s = WAIT_SWAP;
        end else begin
          next_state_s = LOAD;
        end
      end
      WAIT_SWAP: begin
        if (i_Load_start) begin
          next_state_s = LOAD;
          restart_s    = 1'b1;
        end else if (i_Frame_start) begin
          next_state_s = IDLE;
          swap_s       = 1'b1;
        end else begin
          next_state_s = WAIT_SWAP;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register and registered handshake.
  always_ff @(posedge i_Sys_clk) begin
    if (i_Rst) begin
      state_r    <= IDLE;
      wr_ready_r <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      wr_ready_r <= (next_state_s == LOAD);
    end
  end

  // Load progress: write index and running checksum.
  always_ff @(posedge i_Sys_clk) begin
    if (i_Rst) begin
      index_r <= {AW{1'b0}};
      sum_r   <= {SUMW{1'b0}};
    end else if (i_Load_start) begin
      index_r <= {AW{1'b0}};
      sum_r   <= {SUMW{1'b0}};
    end else if (accept_s) begin
      index_r <= index_r + AW'(1);
      sum_r   <= sum_r + {{(SUMW-DW){1'b0}}, i_Wr_data};
    end
  end

  // RAM write port, always aimed at the bank the filter is not reading.
  always_ff @(posedge i_Sys_clk) begin
    if (i_Rst) begin
      ram_we_r    <= 1'b0;
      ram_addr_r  <= {(AW+1){1'b0}};
      ram_wdata_r <= {DW{1'b0}};
    end else begin
      ram_we_r <= accept_s;
      if (accept_s) begin
        ram_addr_r  <= {~rd_bank_r, index_r};
        ram_wdata_r <= i_Wr_data;
      end
    end
  end

  // Bank swap, status pulses and published checksum.
  always_ff @(posedge i_Sys_clk) begin
    if (i_Rst) begin
      rd_bank_r   <= 1'b0;
      load_done_r <= 1'b0;
      load_err_r  <= 1'b0;
      checksum_r  <= {SUMW{1'b0}};
    end else begin
      load_done_r <= swap_s;
      load_err_r  <= restart_s;
      if (swap_s) begin
        rd_bank_r  <= ~rd_bank_r;
        checksum_r <= sum_r;
      end
    end
  end

  assign o_Wr_ready  = wr_ready_r;
  assign o_Ram_we    = ram_we_r;
  assign o_Ram_addr  = ram_addr_r;
  assign o_Ram_wdata = ram_wdata_r;
  assign o_Rd_bank   = rd_bank_r;
  assign o_Load_done = load_done_r;
  assign o_Load_err  = load_err_r;
  assign o_Checksum  = checksum_r;

endmodule

// File: tb/tb_gray_weight_loader.sv
// Self-checking bench for gray_weight_loader (AW=3, DEPTH=8): table of full loads plus
// hand sequences for restart, mistimed frame pulses and mid-load reset.
module tb_gray_weight_loader;
  localparam int DW = 12;
  localparam int AW = 3;
  localparam int SUMW = 16;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            frame_start = 1'b0;
  logic            load_start = 1'b0;
  logic            wr_valid = 1'b0;
  logic [DW-1:0]   wr_data = '0;
  logic            wr_ready;
  logic            ram_we;
  logic [AW:0]     ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic            rd_bank;
  logic            load_done;
  logic            load_err;
  logic [SUMW-1:0] checksum;

  gray_weight_loader #(.DW(DW), .AW(AW), .SUMW(SUMW)) dut (
    .i_Sys_clk(clk), .i_Rst(rst), .i_Frame_start(frame_start), .i_Load_start(load_start),
    .i_Wr_valid(wr_valid), .i_Wr_data(wr_data), .o_Wr_ready(wr_ready), .o_Ram_we(ram_we),
    .o_Ram_addr(ram_addr), .o_Ram_wdata(ram_wdata), .o_Rd_bank(rd_bank),
    .o_Load_done(load_done), .o_Load_err(load_err), .o_Checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]   base;
    logic [DW-1:0]   inc;
    int              max_gap;
    int              frame_delay;
    logic            exp_bank;
    logic [SUMW-1:0] exp_sum;
  } load_vec_t;

  typedef struct {
    logic [AW:0]   addr;
    logic [DW-1:0] data;
  } wr_t;

  int   n_vec = 0;
  int   n_err = 0;
  wr_t  exp_q[$];
  logic bank_m = 1'b0;
  int   idx_m = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Write-port scoreboard: every RAM write must match the next expected entry.
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: addr %0h data %0h at %0t", ram_addr, ram_wdata, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(ram_addr), 32'(e.addr));
        check("wr_data", 32'(ram_wdata), 32'(e.data));
      end
    end
  end

  task automatic start_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    idx_m = 0;
    check("ready_after_start", 32'(wr_ready), 32'd1);
  endtask

  // Offers one word (optionally with a frame pulse on the accept cycle); bounded wait for ready.
  task automatic send_word(input logic [DW-1:0] d, input int gap, input logic fs);
    int waited;
    repeat (gap) step();
    wr_valid = 1'b1;
    wr_data  = d;
    waited   = 0;
    while (wr_ready !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    if (wr_ready !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: got %b expected 1", wr_ready);
    end else begin
      exp_q.push_back('{addr: {~bank_m, AW'(idx_m)}, data: d});
      idx_m++;
      frame_start = fs;
      step();
      frame_start = 1'b0;
    end
    wr_valid = 1'b0;
  endtask

  task automatic load_all(input logic [DW-1:0] base, input logic [DW-1:0] inc, input int max_gap);
    logic [DW-1:0] d;
    d = base;
    for (int i = 0; i < DEPTH; i++) begin
      send_word(d, (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0, 1'b0);
      d = d + inc;
    end
    check("ready_low_after_last", 32'(wr_ready), 32'd0);
  endtask

  task automatic do_swap(input logic [SUMW-1:0] exp_sum);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    bank_m = ~bank_m;
    check("done_pulse", 32'(load_done), 32'd1);
    check("rd_bank_swap", 32'(rd_bank), 32'(bank_m));
    check("checksum", 32'(checksum), 32'(exp_sum));
    step();
    check("done_one_cycle", 32'(load_done), 32'd0);
    check("ready_idle", 32'(wr_ready), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(wr_ready), 32'd0);
    check({tag, "_we"}, 32'(ram_we), 32'd0);
    check({tag, "_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
    check({tag, "_bank"}, 32'(rd_bank), 32'd0);
    check({tag, "_done"}, 32'(load_done), 32'd0);
    check({tag, "_err"}, 32'(load_err), 32'd0);
    check({tag, "_sum"}, 32'(checksum), 32'd0);
  endtask

  initial begin
    load_vec_t vecs[2];
    logic [DW-1:0] d;
    vecs[0] = '{base: 12'd1,     inc: 12'd1, max_gap: 0, frame_delay: 5, exp_bank: 1'b1, exp_sum: 16'd36};
    vecs[1] = '{base: 12'hFFF,   inc: 12'd0, max_gap: 3, frame_delay: 2, exp_bank: 1'b0, exp_sum: 16'h7FF8};

    repeat (2) step();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Table-driven full loads
    for (int v = 0; v < 2; v++) begin
      start_load();
      load_all(vecs[v].base, vecs[v].inc, vecs[v].max_gap);
      for (int w = 0; w < vecs[v].frame_delay; w++) begin
        step();
        check("no_early_done", 32'(load_done), 32'd0);
        check("bank_held", 32'(rd_bank), 32'(bank_m));
      end
      do_swap(vecs[v].exp_sum);
      check("table_bank", 32'(rd_bank), 32'(vecs[v].exp_bank));
    end

    // Restart after 3 words, word offered on the restart cycle is dropped
    start_load();
    for (int i = 0; i < 3; i++) send_word(12'(20 + i), 0, 1'b0);
    wr_valid = 1'b1;
    wr_data  = 12'h5A5;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    wr_valid = 1'b0;
    idx_m = 0;
    check("err_pulse", 32'(load_err), 32'd1);
    check("ready_after_restart", 32'(wr_ready), 32'd1);
    step();
    check("err_one_cycle", 32'(load_err), 32'd0);
    load_all(12'd10, 12'd1, 0);
    step();
    do_swap(16'd108);

    // Frame pulses during LOAD and on the last-word accept do not swap
    start_load();
    d = 12'd100;
    for (int i = 0; i < DEPTH; i++) begin
      send_word(d, 0, (i == 3 || i == DEPTH - 1) ? 1'b1 : 1'b0);
      d = d + 12'd1;
    end
    check("no_swap_last_frame", 32'(rd_bank), 32'(bank_m));
    check("no_done_last_frame", 32'(load_done), 32'd0);
    step();
    check("still_no_done", 32'(load_done), 32'd0);
    do_swap(16'd828);

    // Restart in WAIT_SWAP coincident with a frame pulse
    start_load();
    load_all(12'd7, 12'd3, 0);
    frame_start = 1'b1;
    load_start  = 1'b1;
    step();
    frame_start = 1'b0;
    load_start  = 1'b0;
    idx_m = 0;
    check("ws_err", 32'(load_err), 32'd1);
    check("ws_no_done", 32'(load_done), 32'd0);
    check("ws_bank_held", 32'(rd_bank), 32'(bank_m));
    check("ws_reload", 32'(wr_ready), 32'd1);
    check("ws_sum_held", 32'(checksum), 32'd828);

    // Reset after 4 words of the re-entered load
    for (int i = 0; i < 4; i++) send_word(12'(300 + i), 0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bank_m = 1'b0;
    check_reset_outputs("midrst");
    repeat (3) begin
      step();
      check("ready_stays_low", 32'(wr_ready), 32'd0);
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
